// File: rtl/bit_packer.sv
// bit_packer: assembles a qualified serial bit stream into WIDTH-bit words and
// queues them in a DEPTH-entry FIFO with a valid/ready handshake.
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   asynchronous, active-high; clears all state
//   bit_in       in   serial data bit
//   bit_valid    in   bit_in is sampled on this edge when high
//   align        in   discard the partial word and restart the bit count
//   word_out     out  head-of-buffer word (0 when the buffer is empty)
//   word_valid   out  buffer not empty
//   word_ready   in   consumer accepts word_out this edge
//   overflow     out  sticky: a completed word was dropped
//   overflow_clr in   clears overflow (a coincident drop wins)
//   bit_count    out  bits held in the partial word
module bit_packer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 2,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  input  logic                     align,
  output logic [WIDTH-1:0]         word_out,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic                     overflow,
  input  logic                     overflow_clr,
  output logic [$clog2(WIDTH)-1:0] bit_count
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OccW = $clog2(DEPTH + 1);

  localparam logic [CntW-1:0] LastBit  = CntW'(WIDTH - 1);
  localparam logic [PtrW-1:0] LastSlot = PtrW'(DEPTH - 1);
  localparam logic [OccW-1:0] FullOcc  = OccW'(DEPTH);

  // ---------------------------------------------------------------------------
  // Word assembly
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] first_bit;
  logic             push;
  logic [WIDTH-1:0] push_word;

  always_comb begin
    if (MSB_FIRST) begin
      shifted   = {sr_q[WIDTH-2:0], bit_in};
      first_bit = {{(WIDTH-1){1'b0}}, bit_in};
    end else begin
      shifted   = {bit_in, sr_q[WIDTH-1:1]};
      first_bit = {bit_in, {(WIDTH-1){1'b0}}};
    end
  end

  always_comb begin
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_word = '0;
    if (align) begin
      // Align restarts the word; a simultaneous bit becomes its first bit, so
      // a completion can never happen on an align edge.
      if (bit_valid) begin
        sr_d  = first_bit;
        cnt_d = CntW'(1);
      end else begin
        sr_d  = '0;
        cnt_d = '0;
      end
    end else if (bit_valid) begin
      if (cnt_q == LastBit) begin
        push      = 1'b1;
        push_word = shifted;
        sr_d      = '0;
        cnt_d     = '0;
      end else begin
        sr_d  = shifted;
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]  occ_q, occ_d;
  logic             ovf_q, ovf_d;
  logic             not_empty;
  logic             full;
  logic             pop;
  logic             accept;
  logic             drop;

  assign not_empty = (occ_q != '0);
  assign full      = (occ_q == FullOcc);
  assign pop       = not_empty & word_ready;
  // A pop on the same edge frees the slot, so a full buffer still accepts.
  assign accept    = push & (~full | pop);
  assign drop      = push & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (accept) begin
      wr_ptr_d = (wr_ptr_q == LastSlot) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastSlot) ? '0 : rd_ptr_q + PtrW'(1);
    end
    if (accept && !pop) begin
      occ_d = occ_q + OccW'(1);
    end else if (pop && !accept) begin
      occ_d = occ_q - OccW'(1);
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (overflow_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (accept) begin
      mem_q[wr_ptr_q] <= push_word;
    end
  end

  // Outputs come straight from registered state.
  assign word_valid = not_empty;
  assign word_out   = not_empty ? mem_q[rd_ptr_q] : '0;
  assign overflow   = ovf_q;
  assign bit_count  = cnt_q;

endmodule

// File: tb/tb_bit_packer.sv
module tb_bit_packer;

  logic       clk;
  logic       reset;
  logic       bit_in;
  logic       bit_valid;
  logic       align;
  logic       word_ready;
  logic       overflow_clr;

  logic [7:0] word_out_m, word_out_l;
  logic       word_valid_m, word_valid_l;
  logic       overflow_m, overflow_l;
  logic [2:0] bit_count_m, bit_count_l;

  int checks   = 0;
  int failures = 0;

  bit_packer #(.WIDTH(8), .DEPTH(2), .MSB_FIRST(1'b1)) dut_msb (
    .clk          (clk),
    .reset        (reset),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .align        (align),
    .word_out     (word_out_m),
    .word_valid   (word_valid_m),
    .word_ready   (word_ready),
    .overflow     (overflow_m),
    .overflow_clr (overflow_clr),
    .bit_count    (bit_count_m)
  );

  bit_packer #(.WIDTH(8), .DEPTH(2), .MSB_FIRST(1'b0)) dut_lsb (
    .clk          (clk),
    .reset        (reset),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .align        (align),
    .word_out     (word_out_l),
    .word_valid   (word_valid_l),
    .word_ready   (word_ready),
    .overflow     (overflow_l),
    .overflow_clr (overflow_clr),
    .bit_count    (bit_count_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic bv, input logic bi);
    bit_valid = bv;
    bit_in    = bi;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) step(1'b1, w[i]);
  endtask

  initial begin
    logic [7:0] pat;
    reset        = 1'b1;
    bit_in       = 1'b0;
    bit_valid    = 1'b0;
    align        = 1'b0;
    word_ready   = 1'b0;
    overflow_clr = 1'b0;
    #12;
    chk("rst_valid", word_valid_m, 0);
    chk("rst_count", bit_count_m, 0);
    chk("rst_ovf", overflow_m, 0);
    chk("rst_out", word_out_m, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Basic assembly, both bit orders.
    word_ready = 1'b1;
    pat = 8'hB2;
    for (int i = 7; i >= 0; i--) begin
      step(1'b1, pat[i]);
      chk("t1_count", bit_count_m, (i == 0) ? 0 : 8 - i);
      chk("t1_valid", word_valid_m, (i == 0) ? 1 : 0);
    end
    chk("t1_word_msb", word_out_m, 8'hB2);
    chk("t1_word_lsb", word_out_l, 8'h4D);
    step(1'b0, 1'b0);
    chk("t1_valid_one_cycle", word_valid_m, 0);
    chk("t1_empty_out", word_out_m, 0);

    // Overflow with a stalled consumer.
    word_ready = 1'b0;
    send_word(8'h01);
    send_word(8'h02);
    chk("t3_no_ovf_yet", overflow_m, 0);
    send_word(8'h03);
    chk("t3_ovf", overflow_m, 1);
    chk("t3_head", word_out_m, 8'h01);
    chk("t3_count", bit_count_m, 0);
    step(1'b0, 1'b0);
    chk("t3_hold", word_out_m, 8'h01);
    word_ready = 1'b1;
    step(1'b0, 1'b0);
    chk("t3_pop1", word_out_m, 8'h02);
    step(1'b0, 1'b0);
    chk("t3_pop2_valid", word_valid_m, 0);
    chk("t3_ovf_sticky", overflow_m, 1);
    overflow_clr = 1'b1;
    step(1'b0, 1'b0);
    overflow_clr = 1'b0;
    chk("t3_ovf_clr", overflow_m, 0);

    // Push and pop on the same edge while full.
    word_ready = 1'b0;
    send_word(8'h11);
    send_word(8'h22);
    pat = 8'h33;
    for (int i = 7; i >= 1; i--) step(1'b1, pat[i]);
    word_ready = 1'b1;
    step(1'b1, pat[0]);
    chk("t4_no_ovf", overflow_m, 0);
    chk("t4_valid", word_valid_m, 1);
    chk("t4_head", word_out_m, 8'h22);
    step(1'b0, 1'b0);
    chk("t4_next", word_out_m, 8'h33);
    step(1'b0, 1'b0);
    chk("t4_empty", word_valid_m, 0);

    // Align with a simultaneous bit.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    chk("t5_partial", bit_count_m, 5);
    align = 1'b1;
    step(1'b1, 1'b1);
    align = 1'b0;
    chk("t5_align_count", bit_count_m, 1);
    chk("t5_align_nopush", word_valid_m, 0);
    pat = 8'h01;
    for (int i = 6; i >= 0; i--) step(1'b1, pat[i]);
    chk("t5_valid", word_valid_m, 1);
    chk("t5_word", word_out_m, 8'h81);
    step(1'b0, 1'b0);
    // Align without a bit.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    align = 1'b1;
    step(1'b0, 1'b0);
    align = 1'b0;
    chk("t5_align_clear", bit_count_m, 0);
    chk("t5_align_clear_nopush", word_valid_m, 0);

    // Drop and clear on the same edge: set wins. Then async reset mid-cycle.
    word_ready = 1'b0;
    send_word(8'h5A);
    send_word(8'h5A);
    pat = 8'h5A;
    for (int i = 7; i >= 1; i--) step(1'b1, pat[i]);
    overflow_clr = 1'b1;
    step(1'b1, pat[0]);
    overflow_clr = 1'b0;
    chk("t6_set_wins", overflow_m, 1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    chk("t6_pre_count", bit_count_m, 4);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", word_valid_m, 0);
    chk("t6_rst_count", bit_count_m, 0);
    chk("t6_rst_ovf", overflow_m, 0);
    chk("t6_rst_out", word_out_m, 0);
    @(negedge clk);
    reset = 1'b0;
    send_word(8'hC3);
    chk("t6_word_valid", word_valid_m, 1);
    chk("t6_word", word_out_m, 8'hC3);
    chk("t6_count", bit_count_m, 0);
    word_ready = 1'b1;
    step(1'b0, 1'b0);
    chk("t6_single_word", word_valid_m, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
